gate_preactivation_mac: RTL and testbench

GATE_PREACTIVATION_MAC -- requirements
Module: gate_preactivation_mac

---
 rtl/rnn_fixed_pkg.sv | 19 +
 rtl/fixed_saturate.sv | 24 ++
 rtl/gate_preactivation_mac.sv | 121 ++++++++++++
 tb/tb_gate_preactivation_mac.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rnn_fixed_pkg.sv
// rtl/rnn_fixed_pkg.sv - shared fixed-point format, saturation limits and MAC state encoding
package rnn_fixed_pkg;

    localparam int QN       = 6;
    localparam int QM       = 11;
    localparam int BITWIDTH = QN + QM + 1;

    localparam logic signed [BITWIDTH-1:0] SAT_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [BITWIDTH-1:0] SAT_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        BIAS,
        SAT,
        DONE
    } mac_state_t;

endpackage

// File: rtl/fixed_saturate.sv
// rtl/fixed_saturate.sv - clip a wide signed value into OUT_W bits and flag when clipping occurred
module fixed_saturate #(
    parameter int IN_W  = 40,
    parameter int OUT_W = rnn_fixed_pkg::BITWIDTH
) (
    input  logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0] result,
    output logic                    sat
);

    // The value fits exactly when every bit from OUT_W-1 upward equals the sign.
    logic [IN_W-OUT_W:0] top;
    assign top = value[IN_W-1:OUT_W-1];

    always_comb begin
        sat    = !((&top) || !(|top));
        result = value[OUT_W-1:0];
        if (sat) begin
            result = value[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/gate_preactivation_mac.sv
// rtl/gate_preactivation_mac.sv - streaming dot product plus bias, floor-scaled and saturated
module gate_preactivation_mac #(
    parameter int QN    = rnn_fixed_pkg::QN,
    parameter int QM    = rnn_fixed_pkg::QM,
    parameter int NELEM = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [QN+QM:0] bias,
    input  logic                 in_valid,
    input  logic signed [QN+QM:0] weight,
    input  logic signed [QN+QM:0] data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 out_valid,
    output logic signed [QN+QM:0] result,
    output logic                 sat
);
    import rnn_fixed_pkg::*;

    localparam int BW    = QN + QM + 1;
    localparam int ACC_W = 2 * BW + $clog2(NELEM);
    localparam int CNT_W = $clog2(NELEM + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(NELEM);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NELEM - 1);

    mac_state_t state, state_next;

    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [BW-1:0]    bias_q;
    logic signed [2*BW-1:0]  weight_ext, data_ext, product;
    logic signed [ACC_W-1:0] product_ext, bias_ext, acc_shift;
    logic signed [BW-1:0]    clip_value;
    logic                    clip_sat;
    logic                    accept;

    // Operands widened first so the single multiplier yields the full exact product.
    assign weight_ext  = {{BW{weight[BW-1]}}, weight};
    assign data_ext    = {{BW{data[BW-1]}}, data};
    assign product     = weight_ext * data_ext;
    assign product_ext = {{(ACC_W-2*BW){product[2*BW-1]}}, product};
    assign bias_ext    = {{(ACC_W-BW-QM){bias_q[BW-1]}}, bias_q, {QM{1'b0}}};
    assign acc_shift   = acc >>> QM;

    fixed_saturate #(
        .IN_W  (ACC_W),
        .OUT_W (BW)
    ) u_saturate (
        .value  (acc_shift),
        .result (clip_value),
        .sat    (clip_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = (state != IDLE);
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ACCUM;
            end
            ACCUM: begin
                in_ready = (cnt < CNT_LIMIT);
                accept   = in_valid && in_ready;
                if (accept && cnt == CNT_LAST) state_next = BIAS;
            end
            BIAS:    state_next = SAT;
            SAT:     state_next = DONE;
            DONE: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            cnt    <= '0;
            bias_q <= '0;
            result <= '0;
            sat    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bias_q <= bias;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc + product_ext;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BIAS: acc <= acc + bias_ext;
                SAT: begin
                    result <= clip_value;
                    sat    <= clip_sat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_preactivation_mac.sv
// tb/tb_gate_preactivation_mac.sv - scoreboard bench with directed and random dot products
module tb_gate_preactivation_mac;

    localparam int QN    = 6;
    localparam int QM    = 11;
    localparam int BW    = QN + QM + 1;
    localparam int NELEM = 4;
    localparam longint RMAX = (64'sd1 <<< (BW - 1)) - 1;
    localparam longint RMIN = -(64'sd1 <<< (BW - 1));

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic signed [BW-1:0] bias = '0;
    logic signed [BW-1:0] weight = '0;
    logic signed [BW-1:0] data = '0;
    logic in_ready, busy, out_valid, sat;
    logic signed [BW-1:0] result;

    gate_preactivation_mac #(.QN(QN), .QM(QM), .NELEM(NELEM)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .weight    (weight),
        .data      (data),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint res;
        bit     sat;
        int     cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: exact dot product plus scaled bias, floor division by 2^QM, then clip.
    function automatic exp_t model(input int w[NELEM], input int d[NELEM], input int b, input int acc_cyc);
        exp_t e;
        longint s = 0;
        longint q;
        for (int i = 0; i < NELEM; i++) s += longint'(w[i]) * longint'(d[i]);
        s += longint'(b) * (64'sd1 <<< QM);
        if (s >= 0) q = s / (64'sd1 <<< QM);
        else        q = -((-s + (64'sd1 <<< QM) - 1) / (64'sd1 <<< QM));
        e.sat = (q > RMAX) || (q < RMIN);
        e.res = (q > RMAX) ? RMAX : (q < RMIN) ? RMIN : q;
        e.cyc = acc_cyc + 3;
        return e;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", longint'(result), e.res);
                check("sat", longint'(sat), longint'(e.sat));
                check("latency", cyc, e.cyc);
            end
        end
    end

    function automatic logic signed [BW-1:0] rnd_full();
        logic [31:0] r;
        r = $urandom;
        return r[BW-1:0];
    endfunction

    task automatic run_op(input int w[NELEM], input int d[NELEM], input int b,
                          input int max_gap, input bit spam, input int abort_at);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", 1, 0);
        @(posedge clk); #1;
        start = 1'b1;
        bias  = b[BW-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        bias  = rnd_full();
        for (int i = 0; i < NELEM; i++) begin
            int gap;
            if (abort_at == i) begin
                reset = 1'b0;
                @(negedge clk);
                check("abort_busy", longint'(busy), 0);
                check("abort_out_valid", longint'(out_valid), 0);
                @(posedge clk); #1;
                reset = 1'b1;
                return;
            end
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                start    = spam ? 1'($urandom_range(0, 1)) : 1'b0;
                bias     = rnd_full();
                @(posedge clk); #1;
            end
            start    = spam;
            in_valid = 1'b1;
            weight   = w[i][BW-1:0];
            data     = d[i][BW-1:0];
            @(negedge clk);
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) check("handshake_timeout", 0, 1);
            if (i == NELEM - 1) begin
                last_exp = model(w, d, b, cyc);
                exp_q.push_back(last_exp);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = 1'b0;
            weight   = rnd_full();
            data     = rnd_full();
        end
    endtask

    initial begin
        int w[NELEM];
        int d[NELEM];
        int t;

        @(negedge clk);
        check("reset_busy", longint'(busy), 0);
        check("reset_in_ready", longint'(in_ready), 0);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_result", longint'(result), 0);
        check("reset_sat", longint'(sat), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_op('{2048, 2048, 2048, 2048}, '{2048, 2048, 2048, 2048}, 0, 0, 1'b0, -1);
        run_op('{-2048, -2048, -2048, -2048}, '{3072, 3072, 3072, 3072}, 1024, 0, 1'b0, -1);
        run_op('{63488, 63488, 63488, 63488}, '{63488, 63488, 63488, 63488}, 0, 0, 1'b0, -1);
        run_op('{-63488, -63488, -63488, -63488}, '{63488, 63488, 63488, 63488}, 0, 0, 1'b0, -1);
        run_op('{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 0, 1'b0, -1);
        run_op('{-1, -1, -1, -1}, '{1, 1, 1, 1}, 0, 0, 1'b0, -1);
        run_op('{2048, 2048, 2048, 2048}, '{2048, 2048, 2048, 2048}, 0, 3, 1'b1, -1);
        run_op('{2048, 2048, 2048, 2048}, '{2048, 2048, 2048, 2048}, 0, 3, 1'b1, -1);
        run_op('{-2048, -2048, -2048, -2048}, '{3072, 3072, 3072, 3072}, 1024, 1, 1'b0, 2);
        run_op('{-2048, -2048, -2048, -2048}, '{3072, 3072, 3072, 3072}, 1024, 0, 1'b0, -1);

        for (int r = 0; r < 40; r++) begin
            int mode;
            int b;
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < NELEM; i++) begin
                case (mode)
                    0: begin
                        w[i] = int'($urandom_range(0, 8192)) - 4096;
                        d[i] = int'($urandom_range(0, 8192)) - 4096;
                    end
                    1: begin
                        w[i] = int'(rnd_full());
                        d[i] = int'(rnd_full());
                    end
                    default: begin
                        w[i] = int'($urandom_range(40000, 131071)) * ((r % 2 == 0) ? 1 : -1);
                        d[i] = int'($urandom_range(40000, 131071));
                    end
                endcase
            end
            b = int'(rnd_full());
            run_op(w, d, b, 2, 1'($urandom_range(0, 1)), -1);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("result_hold", longint'(result), last_exp.res);
        check("sat_hold", longint'(sat), longint'(last_exp.sat));
        check("final_idle", longint'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
